// File: rtl/seg8_scan_decoder.sv
// seg8_scan_decoder
// Receive side of the 8-digit multiplexed 7-segment driver. Samples the
// segment and common buses, turns each active-digit pattern back into a BCD
// nibble, and publishes the 32-bit word once digits 0..7 have been seen
// strictly in order.
//
// Ports:
//   i_clk        system clock
//   i_rstn       asynchronous active-low reset
//   i_seg_d      {dot, segments g..a} from the display driver
//   i_seg_com    one-hot digit select, bit7 = digit 0 (bcd[31:28]) .. bit0 = digit 7
//   o_bcd8d      last complete decoded word
//   o_dot        dot bits of the last complete frame, same bit mapping as i_seg_com
//   o_frame_vld  one-cycle pulse when o_bcd8d/o_dot/o_frame_err update
//   o_frame_err  published frame contained an undecodable digit
//   o_seq_err    one-cycle pulse when a frame is abandoned (order or timeout)
module seg8_scan_decoder #(
  parameter int unsigned TIMEOUT_CYC = 200000,
  parameter logic [3:0]  BLANK_CODE  = 4'hF,
  parameter logic [3:0]  ERR_CODE    = 4'hE
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic [7:0]  i_seg_d,
  input  logic [7:0]  i_seg_com,
  output logic [31:0] o_bcd8d,
  output logic [7:0]  o_dot,
  output logic        o_frame_vld,
  output logic        o_frame_err,
  output logic        o_seq_err
);

  localparam int unsigned TmoW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  // The count reaches TIMEOUT_CYC-1 on the edge taken while it holds this value.
  localparam logic [TmoW-1:0] TmoPenult = TmoW'(TIMEOUT_CYC - 2);

  typedef enum logic [0:0] {StIdle, StCollect} state_e;

  state_e          state_q;
  logic [7:0]      seg_q;
  logic [7:0]      com_q;
  logic [7:0]      com_prev_q;
  logic [7:0]      exp_q;
  logic [31:0]     shadow_q;
  logic [7:0]      shadow_dot_q;
  logic            shadow_err_q;
  logic [TmoW-1:0] tmo_q;

  logic       evt;
  logic [3:0] nib;
  logic       nib_err;

  // Only a change on the common bus counts as a driver step.
  assign evt = (com_q != com_prev_q);

  always_comb begin
    nib     = ERR_CODE;
    nib_err = 1'b0;
    case (seg_q[6:0])
      7'h3f:   nib = 4'd0;
      7'h06:   nib = 4'd1;
      7'h5b:   nib = 4'd2;
      7'h4f:   nib = 4'd3;
      7'h66:   nib = 4'd4;
      7'h6d:   nib = 4'd5;
      7'h7d:   nib = 4'd6;
      7'h27:   nib = 4'd7;
      7'h7f:   nib = 4'd8;
      7'h6f:   nib = 4'd9;
      7'h00:   nib = BLANK_CODE;
      default: begin
        nib     = ERR_CODE;
        nib_err = 1'b1;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q      <= StIdle;
      seg_q        <= 8'h00;
      com_q        <= 8'h00;
      com_prev_q   <= 8'h00;
      exp_q        <= 8'h40;
      shadow_q     <= 32'hFFFF_FFFF;
      shadow_dot_q <= 8'h00;
      shadow_err_q <= 1'b0;
      tmo_q        <= '0;
      o_bcd8d      <= 32'hFFFF_FFFF;
      o_dot        <= 8'h00;
      o_frame_vld  <= 1'b0;
      o_frame_err  <= 1'b0;
      o_seq_err    <= 1'b0;
    end else begin
      seg_q       <= i_seg_d;
      com_q       <= i_seg_com;
      com_prev_q  <= com_q;
      o_frame_vld <= 1'b0;
      o_seq_err   <= 1'b0;

      unique case (state_q)
        StIdle: begin
          tmo_q <= '0;
          if (evt && (com_q == 8'h80)) begin
            shadow_q[31:28] <= nib;
            shadow_dot_q[7] <= seg_q[7];
            shadow_err_q    <= nib_err;
            exp_q           <= 8'h40;
            state_q         <= StCollect;
          end
        end

        StCollect: begin
          // An event on the terminal cycle takes priority over the timeout.
          if (evt) begin
            tmo_q <= '0;
            if (com_q == exp_q) begin
              // com_q is one-hot here, so its set bit is the nibble slot.
              for (int p = 0; p < 8; p++) begin
                if (com_q[p]) begin
                  shadow_q[4*p +: 4] <= nib;
                  shadow_dot_q[p]    <= seg_q[7];
                end
              end
              shadow_err_q <= shadow_err_q | nib_err;
              exp_q        <= exp_q >> 1;
              if (com_q[0]) begin
                o_bcd8d     <= {shadow_q[31:4], nib};
                o_dot       <= {shadow_dot_q[7:1], seg_q[7]};
                o_frame_err <= shadow_err_q | nib_err;
                o_frame_vld <= 1'b1;
                state_q     <= StIdle;
              end
            end else if (com_q == 8'h80) begin
              // Restart: the new digit 0 begins a fresh frame.
              o_seq_err       <= 1'b1;
              shadow_q[31:28] <= nib;
              shadow_dot_q[7] <= seg_q[7];
              shadow_err_q    <= nib_err;
              exp_q           <= 8'h40;
            end else begin
              o_seq_err <= 1'b1;
              state_q   <= StIdle;
            end
          end else if (tmo_q == TmoPenult) begin
            o_seq_err <= 1'b1;
            tmo_q     <= '0;
            state_q   <= StIdle;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end

        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_seg8_scan_decoder.sv
module tb_seg8_scan_decoder;

  logic        i_clk;
  logic        i_rstn;
  logic [7:0]  i_seg_d;
  logic [7:0]  i_seg_com;
  logic [31:0] o_bcd8d;
  logic [7:0]  o_dot;
  logic        o_frame_vld;
  logic        o_frame_err;
  logic        o_seq_err;

  seg8_scan_decoder #(
    .TIMEOUT_CYC (8),
    .BLANK_CODE  (4'hF),
    .ERR_CODE    (4'hE)
  ) dut (
    .i_clk       (i_clk),
    .i_rstn      (i_rstn),
    .i_seg_d     (i_seg_d),
    .i_seg_com   (i_seg_com),
    .o_bcd8d     (o_bcd8d),
    .o_dot       (o_dot),
    .o_frame_vld (o_frame_vld),
    .o_frame_err (o_frame_err),
    .o_seq_err   (o_seq_err)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic [31:0] bcd;
    logic [7:0]  dot;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   n_cmp     = 0;
  int   n_bad     = 0;
  int   frame_cnt = 0;
  int   seq_cnt   = 0;
  logic vld_prev  = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] enc(input logic [3:0] n);
    case (n)
      4'd0:    return 7'h3f;
      4'd1:    return 7'h06;
      4'd2:    return 7'h5b;
      4'd3:    return 7'h4f;
      4'd4:    return 7'h66;
      4'd5:    return 7'h6d;
      4'd6:    return 7'h7d;
      4'd7:    return 7'h27;
      4'd8:    return 7'h7f;
      4'd9:    return 7'h6f;
      default: return 7'h00;
    endcase
  endfunction

  // Byte k (k=0 at [63:56]) is the i_seg_d value for digit k.
  function automatic logic [63:0] word_pats(input logic [31:0] w, input logic [7:0] dots);
    logic [63:0] p;
    p = '0;
    for (int k = 0; k < 8; k++) p[63-8*k -: 8] = {dots[7-k], enc(w[31-4*k -: 4])};
    return p;
  endfunction

  // Called at posedge+1; returns at posedge+1 after 'hold' edges.
  task automatic drive(input logic [7:0] seg, input logic [7:0] com, input int hold);
    i_seg_d   = seg;
    i_seg_com = com;
    repeat (hold) @(posedge i_clk);
    #1;
  endtask

  task automatic drive_digit(input logic [63:0] pats, input int k, input int hold);
    drive(pats[63-8*k -: 8], 8'h80 >> k, hold);
  endtask

  task automatic scan(input logic [63:0] pats, input int first, input int last, input int hold);
    for (int k = first; k <= last; k++) drive_digit(pats, k, hold);
  endtask

  // Scoreboard consumer: every publish must match the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge i_clk);
      if (i_rstn) begin
        if (o_seq_err) seq_cnt++;
        if (o_frame_vld) begin
          frame_cnt++;
          check("vld_width", {63'd0, vld_prev}, 64'd0);
          if (sb.size() == 0) begin
            check("unexpected_vld", 64'd1, 64'd0);
          end else begin
            e = sb.pop_front();
            check("bcd", {32'd0, o_bcd8d}, {32'd0, e.bcd});
            check("dot", {56'd0, o_dot}, {56'd0, e.dot});
            check("ferr", {63'd0, o_frame_err}, {63'd0, e.err});
          end
        end
        vld_prev = o_frame_vld;
      end else begin
        vld_prev = 1'b0;
      end
    end
  end

  initial begin
    logic [63:0] pats;
    int          lat;
    int          seq0;
    int          frm0;

    i_rstn    = 1'b0;
    i_seg_d   = 8'h00;
    i_seg_com = 8'h00;
    repeat (3) @(posedge i_clk);
    #1;
    check("rst_bcd", {32'd0, o_bcd8d}, 64'hFFFF_FFFF);
    check("rst_dot", {56'd0, o_dot}, 64'd0);
    check("rst_vld", {63'd0, o_frame_vld}, 64'd0);
    check("rst_ferr", {63'd0, o_frame_err}, 64'd0);
    check("rst_seq", {63'd0, o_seq_err}, 64'd0);
    @(negedge i_clk);
    i_rstn = 1'b1;
    @(posedge i_clk);
    #1;

    // Full frame with 4-clock steps, plus exact publish latency.
    sb.push_back('{bcd: 32'h1234_5678, dot: 8'h00, err: 1'b0});
    pats = word_pats(32'h1234_5678, 8'h00);
    scan(pats, 0, 6, 4);
    i_seg_d   = pats[7:0];
    i_seg_com = 8'h01;
    @(posedge i_clk);
    @(negedge i_clk);
    check("lat_e0", {63'd0, o_frame_vld}, 64'd0);
    @(negedge i_clk);
    check("lat_e1", {63'd0, o_frame_vld}, 64'd1);
    check("lat_bcd", {32'd0, o_bcd8d}, 64'h1234_5678);
    @(negedge i_clk);
    check("lat_w", {63'd0, o_frame_vld}, 64'd0);
    @(posedge i_clk);
    #1;
    check("t1_seq", seq_cnt, 0);
    check("t1_frames", frame_cnt, 1);

    // Blank digit 0, undecodable digit 3, dot on digit 7.
    sb.push_back('{bcd: 32'hF00E_0000, dot: 8'h01, err: 1'b1});
    pats = {8'h00, 8'h3f, 8'h3f, 8'h01, 8'h3f, 8'h3f, 8'h3f, 8'hbf};
    scan(pats, 0, 7, 3);
    repeat (3) @(posedge i_clk);
    #1;

    // Partial scan starting mid-frame is ignored, then a clean frame.
    seq0 = seq_cnt;
    frm0 = frame_cnt;
    pats = word_pats(32'h1111_1111, 8'h00);
    scan(pats, 3, 7, 3);
    repeat (3) @(posedge i_clk);
    #1;
    check("t3_nopub", frame_cnt, frm0);
    check("t3_noseq", seq_cnt, seq0);
    sb.push_back('{bcd: 32'h9999_9999, dot: 8'h00, err: 1'b0});
    scan(word_pats(32'h9999_9999, 8'h00), 0, 7, 2);
    repeat (3) @(posedge i_clk);
    #1;

    // Order violation: 80, 40, 10.
    seq0 = seq_cnt;
    frm0 = frame_cnt;
    pats = word_pats(32'h0000_0000, 8'h00);
    scan(pats, 0, 1, 4);
    drive_digit(pats, 3, 0);
    @(posedge i_clk);
    @(negedge i_clk);
    check("ord_e0", {63'd0, o_seq_err}, 64'd0);
    @(negedge i_clk);
    check("ord_e1", {63'd0, o_seq_err}, 64'd1);
    @(negedge i_clk);
    check("ord_w", {63'd0, o_seq_err}, 64'd0);
    repeat (4) @(posedge i_clk);
    #1;
    check("ord_nopub", frame_cnt, frm0);
    check("ord_hold", {32'd0, o_bcd8d}, 64'h9999_9999);
    check("ord_cnt", seq_cnt, seq0 + 1);
    sb.push_back('{bcd: 32'h2468_1357, dot: 8'h81, err: 1'b0});
    scan(word_pats(32'h2468_1357, 8'h81), 0, 7, 2);
    repeat (3) @(posedge i_clk);
    #1;

    // Timeout: 80, 40, 20, then hold.
    frm0 = frame_cnt;
    scan(pats, 0, 1, 4);
    drive_digit(pats, 2, 0);
    lat = 0;
    for (int i = 1; i <= 14; i++) begin
      @(posedge i_clk);
      #1;
      if (o_seq_err) begin
        lat = i;
        break;
      end
    end
    check("tmo_lat", lat, 9);
    @(posedge i_clk);
    #1;
    check("tmo_w", {63'd0, o_seq_err}, 64'd0);
    repeat (3) @(posedge i_clk);
    #1;

    // Step landing on the terminal cycle is accepted.
    seq0 = seq_cnt;
    sb.push_back('{bcd: 32'h3141_5926, dot: 8'h00, err: 1'b0});
    pats = word_pats(32'h3141_5926, 8'h00);
    scan(pats, 0, 1, 4);
    drive_digit(pats, 2, 7);
    scan(pats, 3, 7, 3);
    repeat (3) @(posedge i_clk);
    #1;
    check("tmo_win_seq", seq_cnt, seq0);
    check("tmo_nopub", frame_cnt, frm0 + 1);

    // Reset mid-frame, then back-to-back 1-clock frames.
    pats = word_pats(32'h5555_5555, 8'h00);
    scan(pats, 0, 4, 2);
    #2;
    i_rstn = 1'b0;
    #1;
    check("mrst_bcd", {32'd0, o_bcd8d}, 64'hFFFF_FFFF);
    check("mrst_dot", {56'd0, o_dot}, 64'd0);
    check("mrst_ferr", {63'd0, o_frame_err}, 64'd0);
    check("mrst_seq", {63'd0, o_seq_err}, 64'd0);
    repeat (2) @(negedge i_clk);
    i_rstn = 1'b1;
    @(posedge i_clk);
    #1;
    sb.push_back('{bcd: 32'h8765_4321, dot: 8'h00, err: 1'b0});
    sb.push_back('{bcd: 32'h0505_0505, dot: 8'h10, err: 1'b0});
    scan(word_pats(32'h8765_4321, 8'h00), 0, 7, 1);
    scan(word_pats(32'h0505_0505, 8'h10), 0, 7, 1);
    repeat (10) @(posedge i_clk);
    #1;

    check("sb_drain", sb.size(), 0);
    check("frames_total", frame_cnt, 7);
    check("seq_total", seq_cnt, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
